sched_ctrl: RTL
===============

SCHED_CTRL -- requirements
Module: sched_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: sys_clk and rst.
REQ-002 sys_clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 blk_valid  in  1  a 512-bit message block is offered on blk_data.
REQ-005 blk_data  in  512  parsed message block; word M0 = blk_data[511:480], M15 = blk_data[31:0].
REQ-006 blk_ready  out  1  the block can accept a message block this cycle.
REQ-007 abort  in  1  synchronous request to drop the current block.
REQ-008 w_valid  out  1  w_data and w_idx hold schedule word W[t].
REQ-009 w_ready  in  1  the round engine consumes W[t] this cycle.
REQ-010 w_data  out  32  schedule word W[t].
REQ-011 w_idx  out  6  t, from 0 to 63.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 done  out  1  one-cycle pulse after W[63] has been consumed.

Function
REQ-014 The states SHALL be IDLE, RUN and DONE, encoded in 2 bits.
REQ-015 blk_ready SHALL equal 1 only in IDLE.
REQ-016 In IDLE, when blk_valid=1, the block SHALL load a 16-word window: win[i] = M_i for i = 0..15.
REQ-017 On that load, the block SHALL clear t to 0 and go to RUN on the next cycle.
REQ-018 In RUN, w_valid SHALL be 1, w_data SHALL be win[0] and w_idx SHALL be t.
REQ-019 A transfer SHALL occur only when w_valid=1 and w_ready=1.
REQ-020 With no transfer, w_data, w_idx and the window SHALL hold their values.
REQ-021 On a transfer, the window SHALL shift by one word: win[i] <= win[i+1] for i = 0..14.
REQ-022 On a transfer, win[15] SHALL be loaded with sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], taken modulo 2^32.
REQ-023 sigma0(x) SHALL be ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-024 sigma1(x) SHALL be ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-025 On a transfer with t < 63, t SHALL increment by 1.
REQ-026 On a transfer with t = 63, the block SHALL go to DONE and t SHALL NOT wrap.
REQ-027 Words W[48..63] SHALL be output using only the shift; no further words need to be valid.
REQ-028 In DONE, done SHALL be 1 and w_valid SHALL be 0 for exactly one cycle, then the state SHALL return to IDLE.
REQ-029 blk_valid SHALL be ignored in RUN and DONE; no block SHALL be loaded in DONE.
REQ-030 The earliest next load SHALL be the cycle after DONE, which gives a back-to-back block period of 66 cycles when w_ready is held at 1.
REQ-031 When abort=1 in RUN or DONE, the state SHALL go to IDLE on the next cycle.
REQ-032 An abort SHALL take effect even if a transfer happens in the same cycle.
REQ-033 On an abort, done SHALL NOT pulse and the window contents are don't-care.
REQ-034 abort in IDLE SHALL have no effect, and abort SHALL win over a simultaneous load.
REQ-035 W[0] SHALL appear one cycle after the load, so the latency from load to W[0] is 1 cycle.
REQ-036 With w_ready held at 1, W[t] SHALL appear t+1 cycles after the load.

Reset
REQ-037 When rst=1, the next state SHALL be IDLE with t=0, w_valid=0, done=0, busy=0, w_data=0 and window=0.
REQ-038 blk_ready SHALL be 1 from the first cycle after reset is released.
REQ-039 rst SHALL take priority over every other input, including in mid-RUN.
REQ-040 A block interrupted by rst SHALL NOT produce a done pulse.

Verification
REQ-041 Test the padded "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018) with w_ready=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, and W63 matching the FIPS 180-4 reference model; done pulses 65 cycles after the load.
REQ-042 Test backpressure by driving w_ready with a random 50% duty -> the word sequence is identical to REQ-041, w_data and w_idx stay stable while w_ready=0, and the number of transfers is exactly 64.
REQ-043 Test back-to-back blocks by holding blk_valid=1 with two different blocks -> the second load happens in the cycle after done, both W sequences match the model, and blk_ready=0 throughout RUN.
REQ-044 Assert abort at t=20 together with w_ready=1 -> IDLE follows on the next cycle with no done pulse; a following block then produces a correct W sequence from t=0.
REQ-045 Assert rst at t=40 -> all outputs return to their reset values on the next cycle and blk_ready=1 afterwards; blk_valid held during rst is not loaded.
REQ-046 Test the boundary at t=63 by holding w_ready=0 for 10 cycles at w_idx=63 -> w_valid stays 1 with no done; when w_ready rises there is one transfer, and then done=1 for one cycle.

Source files
------------

// File: rtl/sched_ctrl_if.sv
// Bus between the message-block source, the schedule controller and the round engine.
// Valid/ready: a block moves when blk_valid && blk_ready; a word W[t] moves when w_valid && w_ready.
interface sched_ctrl_if;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_ready;
    logic         abort;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    modport slave (
        input  blk_valid, blk_data, abort, w_ready,
        output blk_ready, w_valid, w_data, w_idx, busy, done, dbg_state
    );

    modport master (
        output blk_valid, blk_data, abort, w_ready,
        input  blk_ready, w_valid, w_data, w_idx, busy, done, dbg_state
    );
endinterface

// File: rtl/sched_ctrl.sv
// SHA-256 message-schedule generator: loads a 512-bit block into a 16-word window
// and streams W[0..63] to the round engine, extending the window by one word per transfer.
module sched_ctrl (
    input  logic        sys_clk,
    input  logic        rst,
    sched_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_win [16];
    logic [5:0]  r_t;
    logic        r_w_valid;
    logic        r_blk_ready;
    logic        r_busy;
    logic        r_done;

    logic        w_xfer;
    logic        w_load;
    logic [31:0] w_sig0;
    logic [31:0] w_sig1;
    logic [31:0] w_next;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // r_w_valid is only ever set in RUN and r_blk_ready only in IDLE
    assign w_xfer = r_w_valid & bus.w_ready;
    assign w_load = r_blk_ready & bus.blk_valid & ~bus.abort;

    assign w_sig0 = sigma0(r_win[1]);
    assign w_sig1 = sigma1(r_win[14]);
    assign w_next = w_sig1 + r_win[9] + w_sig0 + r_win[0];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_t         <= 6'd0;
            r_w_valid   <= 1'b0;
            r_blk_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_load) begin
                        for (int i = 0; i < 16; i++) begin
                            r_win[i] <= bus.blk_data[511 - 32*i -: 32];
                        end
                        r_t         <= 6'd0;
                        r_state     <= S_RUN;
                        r_w_valid   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_blk_ready <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        for (int i = 0; i < 15; i++) begin
                            r_win[i] <= r_win[i+1];
                        end
                        r_win[15] <= w_next;
                    end
                    // Abort overrides the end-of-block transition taken by a coincident transfer
                    if (bus.abort) begin
                        r_state     <= S_IDLE;
                        r_w_valid   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_blk_ready <= 1'b1;
                        r_done      <= 1'b0;
                    end else if (w_xfer) begin
                        if (r_t == 6'd63) begin
                            r_state   <= S_DONE;
                            r_w_valid <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_t <= r_t + 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_blk_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_w_valid   <= 1'b0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_blk_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.blk_ready = r_blk_ready;
    assign bus.w_valid   = r_w_valid;
    assign bus.w_data    = r_win[0];
    assign bus.w_idx     = r_t;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule
